// File: rtl/apb_pkg.sv
// Shared state encoding, slave decode addresses, size codes and strobe generation
// for the APB round-robin sequencer.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

  localparam logic [31:0] SLV0_ADDR = 32'h0000_4000;
  localparam logic [31:0] SLV1_ADDR = 32'h0000_4001;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Reads never strobe; halfwords are aligned down to the even byte lane pair.
  function automatic logic [3:0] strb_gen(input logic [1:0] size,
                                          input logic [1:0] addr_lo,
                                          input logic       write);
    logic [3:0] s;
    s = 4'b0000;
    if (write) begin
      case (size)
        SIZE_BYTE:        s = 4'b0001 << addr_lo;
        SIZE_HALF:        s = 4'b0011 << {addr_lo[1], 1'b0};
        SIZE_WORD, 2'b11: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid requester at or after ptr,
// wrapping, as a one-hot vector plus its index.
module apb_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any_gnt
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any_gnt && req_valid[cand]) begin
        any_gnt   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_sequencer.sv
// Round-robin APB requester: arbitrates NUM_REQ clients, runs each granted command through
// SETUP/ACCESS with a timeout, and returns read data or error status to the owning client.
module apb_rr_sequencer #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [2*NUM_REQ-1:0]          req_size,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [2:0]                    PPROT,
  output logic                          PSEL0,
  output logic                          PSEL1,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [STRB_WIDTH-1:0]         PSTRB,
  input  logic                          PREADY,
  input  logic [DATA_WIDTH-1:0]         PRDATA
);

  import apb_pkg::*;

  localparam int IW  = $clog2(NUM_REQ);
  localparam int TCW = $clog2(TIMEOUT);

  apb_state_e            state_q, state_d;
  logic [IW-1:0]         ptr_q, own_q, gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  any_gnt;
  logic [TCW-1:0]        tcnt_q;
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  logic [1:0]            size_a  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_hit0, sel_hit1, sel_hit, tmo;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign size_a[i]  = req_size[2*i +: 2];
  end

  apb_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_gnt   (any_gnt)
  );

  assign sel_addr = addr_a[gnt_idx];
  assign sel_hit0 = (sel_addr == ADDR_WIDTH'(SLV0_ADDR));
  assign sel_hit1 = (sel_addr == ADDR_WIDTH'(SLV1_ADDR));
  assign sel_hit  = sel_hit0 | sel_hit1;
  assign tmo      = (tcnt_q == TCW'(TIMEOUT - 1));
  assign PPROT    = 3'b000;

  // Grant is only visible while idle and out of reset, so no handshake is lost to reset.
  assign req_ready = (state_q == IDLE && PRESETn) ? gnt : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = sel_hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PREADY wins over the timeout when both occur in the same ACCESS cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q     <= '0;
      own_q     <= '0;
      tcnt_q    <= '0;
      PSEL0     <= 1'b0;
      PSEL1     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: if (any_gnt) begin
          ptr_q  <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          own_q  <= gnt_idx;
          tcnt_q <= '0;
          if (sel_hit) begin
            PSEL0  <= sel_hit0;
            PSEL1  <= sel_hit1;
            PADDR  <= sel_addr;
            PWRITE <= req_write[gnt_idx];
            PWDATA <= wdata_a[gnt_idx];
            PSTRB  <= STRB_WIDTH'(strb_gen(size_a[gnt_idx], sel_addr[1:0], req_write[gnt_idx]));
          end else begin
            rsp_valid <= gnt;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        SETUP: PENABLE <= 1'b1;
        ACCESS: begin
          if (PREADY || tmo) begin
            PSEL0     <= 1'b0;
            PSEL1     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << own_q;
            rsp_err   <= !PREADY;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
